// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin scheduler sharing one FP adder/subtractor among N_REQ requesters
// Optional WAIT watchdog is compiled in when FPARB_TIMEOUT_EN is defined.
module fp_add_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_y,
  output logic                rsp_err,
  output logic                fp_start,
  output logic                fp_op,
  output logic [31:0]         fp_a,
  output logic [31:0]         fp_b,
  input  logic                fp_ready,
  input  logic                fp_busy,
  input  logic [31:0]         fp_y
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic               boot_cnt_q, boot_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_y_q, rsp_y_d;
  logic               fp_start_q, fp_start_d;
  logic               fp_op_q, fp_op_d;
  logic [31:0]        fp_a_q, fp_a_d;
  logic [31:0]        fp_b_q, fp_b_d;

  logic [31:0]        a_arr [N_REQ];
  logic [31:0]        b_arr [N_REQ];
  logic [PW-1:0]      pick;
  logic [PW-1:0]      cand;
  logic               pick_vld;
  int                 sum;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  // First set request searching upward from rr_ptr with wrap.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    sum      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = PW'(sum);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef FPARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout;
  assign timeout = (wait_cnt_q == 16'(TIMEOUT_CYCLES));
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    boot_cnt_d  = 1'b0;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    fp_start_d  = 1'b0;
    fp_op_d     = fp_op_q;
    fp_a_d      = fp_a_q;
    fp_b_d      = fp_b_q;
`ifdef FPARB_TIMEOUT_EN
    wait_cnt_d  = '0;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      // The adder has no reset: hold off until it has drained any stale op.
      S_BOOT: begin
        boot_cnt_d = 1'b1;
        if (boot_cnt_q && !fp_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d[pick] = 1'b1;
          fp_a_d      = a_arr[pick];
          fp_b_d      = b_arr[pick];
          fp_op_d     = req_op[pick];
          owner_d     = pick;
          rr_ptr_d    = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fp_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (fp_ready) begin
          rsp_y_d              = fp_y;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
`ifdef FPARB_TIMEOUT_EN
          rsp_err_d            = 1'b0;
        end else if (timeout) begin
          rsp_y_d              = 32'h7FC00000;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end else begin
          wait_cnt_d           = wait_cnt_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
`ifdef FPARB_TIMEOUT_EN
        state_d = rsp_err_q ? S_BOOT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      boot_cnt_q  <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      fp_start_q  <= 1'b0;
      fp_op_q     <= 1'b0;
      fp_a_q      <= '0;
      fp_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      boot_cnt_q  <= boot_cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      fp_start_q  <= fp_start_d;
      fp_op_q     <= fp_op_d;
      fp_a_q      <= fp_a_d;
      fp_b_q      <= fp_b_d;
    end
  end

`ifdef FPARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign fp_start  = fp_start_q;
  assign fp_op     = fp_op_q;
  assign fp_a      = fp_a_q;
  assign fp_b      = fp_b_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter with a stub adder
module tb_fp_add_arbiter;

  localparam int N = 4;
`ifdef FPARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, req_op;
  logic [32*N-1:0]  req_a, req_b;
  logic [N-1:0]     gnt, rsp_valid;
  logic [31:0]      rsp_y;
  logic             rsp_err;
  logic             fp_start, fp_op;
  logic [31:0]      fp_a, fp_b;
  logic             fp_ready, fp_busy;
  logic [31:0]      fp_y;

  always #5 clk = ~clk;

  fp_add_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
    .fp_ready(fp_ready), .fp_busy(fp_busy), .fp_y(fp_y)
  );

  // Stub adder: no reset, fixed latency, hand-computed IEEE-754 results.
  logic        stub_ready = 1'b0;
  logic        stub_busy  = 1'b0;
  logic [31:0] stub_y     = '0;
  logic [31:0] stub_res   = '0;
  int          stub_cnt   = 0;
  int          stub_lat   = 3;
  bit          stub_mute  = 1'b0;
  logic        inj_ready  = 1'b0;
  logic [31:0] inj_y      = '0;

  assign fp_ready = stub_ready | inj_ready;
  assign fp_busy  = stub_busy;
  assign fp_y     = inj_ready ? inj_y : stub_y;

  function automatic logic [31:0] fp_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h40A00000, 32'h40400000}: return 32'h41000000;
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    stub_ready <= 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_ready <= 1'b1;
        stub_busy  <= 1'b0;
        stub_y     <= stub_res;
      end
    end else if (fp_start && !stub_mute) begin
      stub_cnt  <= stub_lat;
      stub_busy <= 1'b1;
      stub_res  <= fp_model(fp_op, fp_a, fp_b);
    end
  end

  int cyc = 0, gnt_cyc = 0, start_cyc = 0, ready_cyc = 0, rsp_cyc = 0;
  int rsp_cnt = 0, start_hi = 0, onehot_bad = 0, overlap_bad = 0;
  bit inflight = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) inflight = 1'b0;
    if (gnt != '0) begin
      gnt_cyc = cyc;
      if ($countones(gnt) != 1) onehot_bad++;
      if (inflight) overlap_bad++;
      inflight = 1'b1;
    end
    if (rsp_valid != '0) begin
      rsp_cyc = cyc;
      rsp_cnt++;
      if ($countones(rsp_valid) != 1) onehot_bad++;
      inflight = 1'b0;
    end
    if (fp_start) begin
      start_cyc = cyc;
      start_hi++;
    end
    if (fp_ready) ready_cyc = cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin step(); n++; end while (gnt == '0 && n < 200);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin step(); n++; end while (rsp_valid == '0 && n < 200);
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    req[i]           = 1'b1;
    req_op[i]        = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  logic [3:0]  t3_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [31:0] t3_y [6] = '{32'h40400000, 32'h40000000, 32'h41000000,
                            32'h40400000, 32'h40000000, 32'h41000000};

  initial begin
    int n;
    int rsp_base;
    rst_n = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) step();
    check("rst_gnt",       32'(gnt),       32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_y",     rsp_y,          32'h0);
    check("rst_rsp_err",   32'(rsp_err),   32'h0);
    check("rst_fp_start",  32'(fp_start),  32'h0);
    check("rst_fp_op",     32'(fp_op),     32'h0);
    check("rst_fp_a",      fp_a,           32'h0);
    check("rst_fp_b",      fp_b,           32'h0);

    // 1: 1.0 + 2.0 from requester 0 straight out of reset
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    rst_n = 1'b1;
    start_hi = 0;
    wait_gnt(n);
    check("t1_boot_wait", 32'(n >= 3), 32'h1);
    req = '0;
    check("t1_gnt",  32'(gnt), 32'h1);
    check("t1_fp_a", fp_a,     32'h3F800000);
    check("t1_fp_b", fp_b,     32'h40000000);
    check("t1_fp_op", 32'(fp_op), 32'h0);
    wait_rsp(n);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_y",     rsp_y,          32'h40400000);
    check("t1_rsp_err",   32'(rsp_err),   32'h0);
    check("t1_start_lat", 32'(start_cyc - gnt_cyc), 32'h1);
    check("t1_start_width", 32'(start_hi), 32'h1);
    check("t1_rsp_lat",   32'(rsp_cyc - ready_cyc), 32'h1);
    step();
    check("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

    // 2: 3.0 - 1.0 from requester 2
    set_req(2, 1'b1, 32'h40400000, 32'h3F800000);
    wait_gnt(n);
    req = '0;
    check("t2_gnt", 32'(gnt), 32'h4);
    wait_rsp(n);
    check("t2_rsp_valid", 32'(rsp_valid), 32'h4);
    check("t2_rsp_y",     rsp_y,          32'h40000000);
    check("t2_rsp_err",   32'(rsp_err),   32'h0);

    // 5: spurious fp_ready in IDLE
    repeat (2) step();
    rsp_base = rsp_cnt;
    inj_y = 32'h12345678;
    inj_ready = 1'b1;
    step();
    inj_ready = 1'b0;
    repeat (4) step();
    check("t5_no_rsp",   32'(rsp_cnt - rsp_base), 32'h0);
    check("t5_rsp_y_held", rsp_y, 32'h40000000);
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_gnt(n);
    req = '0;
    check("t5_idle_gnt_lat", 32'(n), 32'h1);
    check("t5_gnt", 32'(gnt), 32'h1);
    wait_rsp(n);
    check("t5_rsp_y", rsp_y, 32'h40400000);

    // 4: reset while in WAIT, stale completion lands in BOOT
    set_req(1, 1'b1, 32'h40400000, 32'h3F800000);
    stub_lat = 12;
    wait_gnt(n);
    req = '0;
    check("t4_gnt", 32'(gnt), 32'h2);
    repeat (3) step();
    rsp_base = rsp_cnt;
    rst_n = 1'b0;
    step();
    check("t4_rst_fp_a",  fp_a, 32'h0);
    check("t4_rst_fp_op", 32'(fp_op), 32'h0);
    step();
    rst_n = 1'b1;
    stub_lat = 3;
    set_req(3, 1'b0, 32'h40A00000, 32'h40400000);
    wait_gnt(n);
    req = '0;
    check("t4_gnt_after_boot", 32'(gnt), 32'h8);
    check("t4_boot_wait",  32'(n >= 3), 32'h1);
    check("t4_busy_at_gnt", 32'(fp_busy), 32'h0);
    check("t4_stale_before_gnt", 32'(ready_cyc < gnt_cyc), 32'h1);
    check("t4_no_stale_rsp", 32'(rsp_cnt - rsp_base), 32'h0);
    wait_rsp(n);
    check("t4_rsp_valid", 32'(rsp_valid), 32'h8);
    check("t4_rsp_y",     rsp_y,          32'h41000000);

    // 3: req=1011 held, rr_ptr restarted at 0 by the reset above
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    set_req(1, 1'b1, 32'h40400000, 32'h3F800000);
    set_req(3, 1'b0, 32'h40A00000, 32'h40400000);
    for (int i = 0; i < 6; i++) begin
      wait_gnt(n);
      check($sformatf("t3_gnt%0d", i), 32'(gnt), 32'(t3_g[i]));
      if (i == 5) req = '0;
      wait_rsp(n);
      check($sformatf("t3_rsp_valid%0d", i), 32'(rsp_valid), 32'(t3_g[i]));
      check($sformatf("t3_rsp_y%0d", i), rsp_y, t3_y[i]);
    end

`ifdef FPARB_TIMEOUT_EN
    // 6: adder never answers, watchdog aborts and re-enters BOOT
    repeat (2) step();
    stub_mute = 1'b1;
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_gnt(n);
    req = '0;
    wait_rsp(n);
    check("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t6_timeout_lat", 32'(rsp_cyc - start_cyc), 32'd9);
    check("t6_rsp_y",   rsp_y,        32'h7FC00000);
    check("t6_rsp_err", 32'(rsp_err), 32'h1);
    stub_mute = 1'b0;
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    wait_gnt(n);
    req = '0;
    check("t6_boot_regrant", 32'(gnt_cyc - rsp_cyc), 32'd4);
    wait_rsp(n);
    check("t6_recover_y",   rsp_y,        32'h40400000);
    check("t6_recover_err", 32'(rsp_err), 32'h0);
`endif

    check("onehot_violations",  32'(onehot_bad),  32'h0);
    check("overlap_violations", 32'(overlap_bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
